// File: rtl/ascon_pkg.sv
// Shared types and constants for the Ascon-Hash256 controller.
//   ascon_word_t    : 64-bit state/message/digest word
//   hash_state_t    : controller FSM states
//   hash_phase_t    : which permutation the controller is waiting on
package ascon_pkg;

  localparam int unsigned WORD_W    = 64;
  localparam int unsigned SEL_W     = 3;
  localparam int unsigned NBYTES_W  = 4;
  localparam int unsigned NUM_WORDS = 5;

  typedef logic [WORD_W-1:0] ascon_word_t;

  localparam ascon_word_t ASCON_HASH256_IV = 64'h0000_0801_00CC_0002;
  localparam ascon_word_t ASCON_PAD_ONE    = 64'h0000_0000_0000_0001;
  localparam logic        ROUND_CFG_P12    = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PERM,
    WAIT,
    ABSORB,
    PADBLK,
    SQUEEZE
  } hash_state_t;

  // PH_PAD: a full 8-byte last word was absorbed, an extra padding block follows.
  typedef enum logic [1:0] {
    PH_INIT,
    PH_ABSORB,
    PH_PAD,
    PH_FINAL
  } hash_phase_t;

endpackage

// File: rtl/ascon_pad_word.sv
// Masks a final message word to its valid bytes and appends the 0x01 pad byte.
//   word    : raw message word, byte 0 at bits [7:0]
//   nbytes  : valid bytes 0..8 (9..15 behave as 8, i.e. the word passes unchanged)
//   padded  : masked word with 0x01 placed in byte position nbytes
module ascon_pad_word
  import ascon_pkg::*;
(
  input  ascon_word_t         word,
  input  logic [NBYTES_W-1:0] nbytes,
  output ascon_word_t         padded
);

  localparam int unsigned BYTES = WORD_W / 8;

  logic [NBYTES_W-1:0] n;

  // Byte-wise select: keep valid bytes, pad byte at position n, zeros above.
  always_comb begin
    n      = (nbytes > NBYTES_W'(BYTES)) ? NBYTES_W'(BYTES) : nbytes;
    padded = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (NBYTES_W'(i) < n) begin
        padded[8*i +: 8] = word[8*i +: 8];
      end else if (NBYTES_W'(i) == n) begin
        padded[8*i +: 8] = 8'h01;
      end
    end
  end

endmodule

// File: rtl/ascon_hash_ctrl.sv
// Sequencer driving an external Ascon permutation core through Ascon-Hash256.
//   start_i/msg_*          : start request and message word stream (valid/ready)
//   dig_*                  : four-word digest stream (valid/ready), last on word 3
//   busy_o                 : controller not idle
//   core_*                 : word-addressed access and p12 start/ready to the core
module ascon_hash_ctrl
  import ascon_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  ascon_word_t         msg_data_i,
  input  logic                msg_valid_i,
  input  logic                msg_last_i,
  input  logic [NBYTES_W-1:0] msg_bytes_i,
  output logic                msg_ready_o,
  output ascon_word_t         dig_data_o,
  output logic                dig_valid_o,
  output logic                dig_last_o,
  input  logic                dig_ready_i,
  output logic                busy_o,
  output logic                core_start_perm_o,
  output logic                core_round_config_o,
  output logic [SEL_W-1:0]    core_word_sel_o,
  output ascon_word_t         core_data_o,
  output logic                core_write_en_o,
  output logic                core_xor_en_o,
  input  ascon_word_t         core_data_i,
  input  logic                core_ready_i
);

  localparam logic [SEL_W-1:0] LOAD_LAST = SEL_W'(NUM_WORDS - 1);

  hash_state_t        state, state_d;
  hash_phase_t        phase, phase_d;
  logic [SEL_W-1:0]   load_cnt, load_cnt_d;
  logic [1:0]         dig_cnt, dig_cnt_d;
  ascon_word_t        padded_word;
  logic               full_last;

  ascon_pad_word u_pad (
    .word   (msg_data_i),
    .nbytes (msg_bytes_i),
    .padded (padded_word)
  );

  assign full_last = (msg_bytes_i >= NBYTES_W'(8));

  // State, phase and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      phase    <= PH_INIT;
      load_cnt <= '0;
      dig_cnt  <= '0;
    end else begin
      state    <= state_d;
      phase    <= phase_d;
      load_cnt <= load_cnt_d;
      dig_cnt  <= dig_cnt_d;
    end
  end

  // Next-state and output decode; outputs follow the state register so reset
  // clears them immediately.
  always_comb begin
    state_d             = state;
    phase_d             = phase;
    load_cnt_d          = load_cnt;
    dig_cnt_d           = dig_cnt;
    busy_o              = (state != IDLE);
    msg_ready_o         = 1'b0;
    dig_data_o          = '0;
    dig_valid_o         = 1'b0;
    dig_last_o          = 1'b0;
    core_start_perm_o   = 1'b0;
    core_round_config_o = ROUND_CFG_P12;
    core_word_sel_o     = '0;
    core_data_o         = '0;
    core_write_en_o     = 1'b0;
    core_xor_en_o       = 1'b0;

    case (state)
      IDLE: begin
        if (start_i) begin
          state_d    = LOAD;
          phase_d    = PH_INIT;
          load_cnt_d = '0;
          dig_cnt_d  = '0;
        end
      end

      // Word 4 is rewritten until the core is free, which is harmless.
      LOAD: begin
        core_write_en_o = 1'b1;
        core_word_sel_o = load_cnt;
        core_data_o     = (load_cnt == '0) ? ASCON_HASH256_IV : '0;
        if (load_cnt == LOAD_LAST) begin
          if (core_ready_i) begin
            state_d = PERM;
          end
        end else begin
          load_cnt_d = load_cnt + SEL_W'(1);
        end
      end

      PERM: begin
        core_start_perm_o = 1'b1;
        state_d           = WAIT;
      end

      WAIT: begin
        if (core_ready_i) begin
          case (phase)
            PH_PAD:   state_d = PADBLK;
            PH_FINAL: state_d = SQUEEZE;
            default:  state_d = ABSORB;
          endcase
        end
      end

      ABSORB: begin
        msg_ready_o = core_ready_i;
        if (msg_valid_i && core_ready_i) begin
          core_xor_en_o = 1'b1;
          core_data_o   = msg_last_i ? padded_word : msg_data_i;
          if (msg_last_i) begin
            phase_d = full_last ? PH_PAD : PH_FINAL;
          end else begin
            phase_d = PH_ABSORB;
          end
          state_d = PERM;
        end
      end

      PADBLK: begin
        core_xor_en_o = 1'b1;
        core_data_o   = ASCON_PAD_ONE;
        phase_d       = PH_FINAL;
        state_d       = PERM;
      end

      SQUEEZE: begin
        dig_valid_o = 1'b1;
        dig_data_o  = core_data_i;
        dig_last_o  = (dig_cnt == 2'd3);
        if (dig_ready_i) begin
          dig_cnt_d = dig_cnt + 2'd1;
          state_d   = (dig_cnt == 2'd3) ? IDLE : PERM;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
